// File: rtl/register_memory.sv
// 32 x DATA_WIDTH integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional REGMEM_BYPASS_EN forwards a same-cycle write to a matching read port.
module register_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_address_a,
  input  logic [ADDR_WIDTH-1:0] rd_address_b,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_RD = 2;

  // x0 has no storage, so the array starts at index 1.
  logic [DEPTH-1:1][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic                              wr_hit;

  assign wr_hit = wr_enable && (wr_address != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wr_address] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rd_addr[0] = rd_address_a;
  assign rd_addr[1] = rd_address_b;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      rd_data[p] = '0;
      if (rd_addr[p] != '0) begin
`ifdef REGMEM_BYPASS_EN
        if (wr_hit && (wr_address == rd_addr[p])) rd_data[p] = wr_data;
        else                                      rd_data[p] = regs_q[rd_addr[p]];
`else
        rd_data[p] = regs_q[rd_addr[p]];
`endif
      end
    end
  end

  assign data_out_a = rd_data[0];
  assign data_out_b = rd_data[1];
endmodule

// File: tb/tb_register_memory.sv
// Self-checking bench for register_memory: directed plan followed by randomized traffic against an array model.
module tb_register_memory;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_address_a, rd_address_b, wr_address;
  logic          wr_enable;
  logic [DW-1:0] wr_data, data_out_a, data_out_b;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl [32];

  register_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_address_a(rd_address_a), .rd_address_b(rd_address_b),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
    .data_out_a(data_out_a), .data_out_b(data_out_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Edge, then apply the architectural effect of the inputs that were sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (wr_enable && wr_address != 0) begin
      mdl[wr_address] = wr_data;
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGMEM_BYPASS_EN
    if (rst_n !== 1'bx && wr_enable && wr_address == a) return wr_data;
`endif
    return mdl[a];
  endfunction

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_address_a = a;
    rd_address_b = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_enable = 1'b0; wr_address = '0; wr_data = '0;
    rd_address_a = '0; rd_address_b = '0;
    #1;
    chk("x0_prereset_a", data_out_a, 32'h0);
    chk("x0_prereset_b", data_out_b, 32'h0);

    tick();
    rst_n = 1'b1;
    rd(5'd0, 5'd1);
    chk("rst_a0", data_out_a, 32'h0);
    chk("rst_b1", data_out_b, 32'h0);
    rd(5'd31, 5'd31);
    chk("rst_a31", data_out_a, 32'h0);
    chk("rst_b31", data_out_b, 32'h0);

    wr_enable = 1'b1; wr_address = 5'd0; wr_data = 32'hEEEEEEEE;
    rd(5'd0, 5'd0);
    tick();
    wr_enable = 1'b0;
    #1;
    chk("x0_wr_a", data_out_a, 32'h0);
    chk("x0_wr_b", data_out_b, 32'h0);

    wr_enable = 1'b1; wr_address = 5'hA; wr_data = 32'hABCDEFAB;
    tick();
    wr_enable = 1'b0;
    rd(5'hA, 5'hA);
    chk("wr10_a", data_out_a, 32'hABCDEFAB);
    chk("wr10_b", data_out_b, 32'hABCDEFAB);

    wr_enable = 1'b0; wr_address = 5'hA; wr_data = 32'h12345678;
    tick();
    chk("wen0_hold", data_out_a, 32'hABCDEFAB);

    wr_enable = 1'b1; wr_address = 5'd31; wr_data = 32'h0000001F;
    tick();
    wr_enable = 1'b0;
    rd(5'd31, 5'd10);
    chk("indep_a31", data_out_a, 32'h0000001F);
    chk("indep_b10", data_out_b, 32'hABCDEFAB);

    rst_n = 1'b0; wr_enable = 1'b1; wr_address = 5'd5; wr_data = 32'hFFFFFFFF;
    tick();
    rst_n = 1'b1; wr_enable = 1'b0;
    rd(5'd5, 5'd10);
    chk("rstprio_a5", data_out_a, 32'h0);
    chk("rstprio_b10", data_out_b, 32'h0);

    wr_enable = 1'b1; wr_address = 5'd3; wr_data = 32'hCAFEBABE;
    rd(5'd3, 5'd4);
`ifdef REGMEM_BYPASS_EN
    chk("hazard_pre", data_out_a, 32'hCAFEBABE);
`else
    chk("hazard_pre", data_out_a, 32'h0);
`endif
    chk("hazard_other", data_out_b, 32'h0);
    tick();
    wr_enable = 1'b0;
    #1;
    chk("hazard_post", data_out_a, 32'hCAFEBABE);

    // Random traffic; addresses drawn from a small pool so hazards and x0 hits are frequent.
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      wr_enable    = $urandom_range(0, 2) != 0;
      wr_address   = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31));
      wr_data      = DW'($urandom);
      rd_address_a = ($urandom_range(0, 3) == 0) ? wr_address : AW'($urandom_range(0, 31));
      rd_address_b = ($urandom_range(0, 3) == 0) ? wr_address : AW'($urandom_range(0, 31));
      #2;
      chk("rnd_pre_a", data_out_a, exp_rd(rd_address_a));
      chk("rnd_pre_b", data_out_b, exp_rd(rd_address_b));
      tick();
      chk("rnd_post_a", data_out_a, exp_rd(rd_address_a));
      chk("rnd_post_b", data_out_b, exp_rd(rd_address_b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_memory.md
Name: register_memory

Overview:
- RISC-V style integer register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Register x0 is hardwired to zero.
- Sits in the core datapath between decode (which supplies the rs1/rs2/rd addresses) and execute/writeback.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 entries).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- rd_address_a  input  ADDR_WIDTH  read port A address (rs1).
- rd_address_b  input  ADDR_WIDTH  read port B address (rs2).
- wr_enable  input  1  write strobe, sampled on rising clk.
- wr_address  input  ADDR_WIDTH  write address (rd).
- wr_data  input  DATA_WIDTH  write data.
- data_out_a  output  DATA_WIDTH  contents of register rd_address_a.
- data_out_b  output  DATA_WIDTH  contents of register rd_address_b.

Behaviour:
- Reset:
  - On a rising clk edge with rst_n=0, registers x1..x31 are cleared to 0.
  - Reset has priority over a simultaneous write.
  - After reset, both outputs read 0 for any address.
- Write:
  - On a rising clk edge with rst_n=1, wr_enable=1 and wr_address!=0, wr_data is stored in register wr_address.
  - With wr_enable=0, no register changes.
- Register 0:
  - Never stored; writes to address 0 are silently dropped.
  - Any read of address 0 returns 0 at all times, including before the first reset.
- Read:
  - Purely combinational (zero latency) from the register array.
  - A value written on edge N is visible on data_out_a/b immediately after edge N, with no extra cycle.
- Both ports:
  - Ports are independent and may address the same register simultaneously; both then return identical data.
- Same-cycle read/write of the same address (before the edge):
  - Without the optional feature, the output shows the old contents until the edge.
- Uninitialised state:
  - Before the first reset, x1..x31 contents are undefined (X in simulation).
  - x0 still reads 0.
- No other state, no handshake, no error signalling.
- Address inputs are always fully decoded; there are no out-of-range addresses.

Optional Feature:
- Macro: REGMEM_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wr_enable=1, wr_address!=0 and wr_address equals a read address, that port outputs wr_data combinationally in the same cycle, before the edge.
  - Forwarding is evaluated independently per port.
  - Address 0 is never forwarded; it still reads 0.
- Not defined: outputs reflect only stored contents; a new value appears after the rising edge.

Test Plan:
- Reset then read: rst_n=0 for one edge, then rst_n=1; read addresses 0, 1, 31 on both ports -> data_out_a = data_out_b = 32'h00000000.
- x0 unwritable: wr_enable=1, wr_address=0, wr_data=32'hEEEEEEEE, clock edge, read A=B=0 -> both outputs 32'h00000000.
- Write/readback: wr_enable=1, wr_address=5'hA, wr_data=32'hABCDEFAB, edge, then wr_enable=0, read A=B=5'hA -> both outputs 32'hABCDEFAB right after the edge.
- Write disabled and independent ports:
  - wr_enable=0, wr_address=5'hA, wr_data=32'h12345678, edge -> reg 10 still reads 32'hABCDEFAB.
  - Write 32'h0000001F to reg 31, then read A=31, B=10 -> A=32'h0000001F, B=32'hABCDEFAB.
- Reset priority: rst_n=0 with wr_enable=1, wr_address=5, wr_data=32'hFFFFFFFF, edge -> reg 5 reads 32'h0; reg 10 also reads 32'h0.
- Same-cycle hazard:
  - Set wr_enable=1, wr_address=3, wr_data=32'hCAFEBABE, read A=3, sample before the edge.
  - Without REGMEM_BYPASS_EN -> old value (0 after reset).
  - With REGMEM_BYPASS_EN -> 32'hCAFEBABE.
  - In both builds, after the edge -> 32'hCAFEBABE.
